// File: rtl/nibble_serial_compare_ctrl_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_compare_ctrl_if
//   Handshake bundle for nibble_serial_compare_ctrl.
//   master : operand producer / result consumer (drives in_valid, a, b,
//            out_ready).
//   slave  : the compare sequencer (drives in_ready, out_valid, eq, gt, lt,
//            count).
//   Signals:
//     in_valid/in_ready   operand-pair handshake
//     a, b                unsigned operands, 4*NIBBLES bits
//     out_valid/out_ready result handshake
//     eq, gt, lt          one-hot result while out_valid
//     count               nibbles examined, 1..NIBBLES
// ---------------------------------------------------------------------------
interface nibble_serial_compare_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic          eq;
    logic          gt;
    logic          lt;
    logic [CW-1:0] count;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, eq, gt, lt, count
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, eq, gt, lt, count
    );
endinterface

// File: rtl/nibble_serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_compare_ctrl
//   Compares two unsigned 4*NIBBLES-bit operands with a single 4-bit
//   magnitude-compare slice, one nibble per clock, most-significant nibble
//   first. With EARLY_EXIT=1 it finishes on the first unequal nibble;
//   otherwise it always scans every nibble.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    slave side of nibble_serial_compare_ctrl_if (operand and result
//            valid/ready handshakes, eq/gt/lt one-hot result, count)
// ---------------------------------------------------------------------------
module nibble_serial_compare_ctrl #(
    parameter int NIBBLES    = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_compare_ctrl_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES) + 1;
    // idx needs at least one bit even when there is a single nibble
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [IW-1:0] idx;
    logic          diff_seen;   // an unequal nibble has already been found
    logic          diff_gt;     // direction of that first difference
    logic          out_valid_r;
    logic          eq_r;
    logic          gt_r;
    logic          lt_r;
    logic [CW-1:0] count_r;

    // Shared 4-bit compare slice on the nibble selected by idx.
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic          nib_ne;
    logic          nib_gt;
    logic          seen_next;
    logic          gt_next;
    logic          finish;

    always_comb begin
        a_sh      = a_r >> {idx, 2'b00};
        b_sh      = b_r >> {idx, 2'b00};
        nib_a     = a_sh[3:0];
        nib_b     = b_sh[3:0];
        nib_ne    = (nib_a != nib_b);
        nib_gt    = (nib_a > nib_b);
        // Only the most-significant difference decides the result.
        seen_next = diff_seen | nib_ne;
        gt_next   = diff_seen ? diff_gt : nib_gt;
        finish    = (EARLY_EXIT && nib_ne) || (idx == '0);
    end

    // NOTE: in_ready is a pure decode of state, so it can never combinationally
    // depend on in_valid and no same-cycle DONE->accept path exists.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.eq        = eq_r;
    assign bus.gt        = gt_r;
    assign bus.lt        = lt_r;
    assign bus.count     = count_r;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            idx         <= '0;
            diff_seen   <= 1'b0;
            diff_gt     <= 1'b0;
            out_valid_r <= 1'b0;
            eq_r        <= 1'b0;
            gt_r        <= 1'b0;
            lt_r        <= 1'b0;
            count_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r       <= bus.a;
                        b_r       <= bus.b;
                        idx       <= IW'(NIBBLES - 1);
                        diff_seen <= 1'b0;
                        diff_gt   <= 1'b0;
                        state     <= CMP;
                    end
                end
                CMP: begin
                    diff_seen <= seen_next;
                    diff_gt   <= gt_next;
                    if (finish) begin
                        eq_r        <= ~seen_next;
                        gt_r        <= seen_next & gt_next;
                        lt_r        <= seen_next & ~gt_next;
                        count_r     <= CW'(NIBBLES) - CW'(idx);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    // eq/gt/lt/count stay put until the next result is loaded.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_compare_ctrl
//   Drives two instances side by side from the same stimulus: dut_e with
//   EARLY_EXIT=1 and dut_f with EARLY_EXIT=0, both with NIBBLES=4. Expected
//   results come from a reference model that uses whole-word unsigned
//   comparison and the position of the highest differing bit.
// ---------------------------------------------------------------------------
module tb_nibble_serial_compare_ctrl;
    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_compare_ctrl_if #(.NIBBLES(NIB)) bus_e ();
    nibble_serial_compare_ctrl_if #(.NIBBLES(NIB)) bus_f ();

    assign bus_e.in_valid  = in_valid;
    assign bus_e.a         = a_in;
    assign bus_e.b         = b_in;
    assign bus_e.out_ready = out_ready;
    assign bus_f.in_valid  = in_valid;
    assign bus_f.a         = a_in;
    assign bus_f.b         = b_in;
    assign bus_f.out_ready = out_ready;

    nibble_serial_compare_ctrl #(.NIBBLES(NIB), .EARLY_EXIT(1'b1)) dut_e (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_e)
    );

    nibble_serial_compare_ctrl #(.NIBBLES(NIB), .EARLY_EXIT(1'b0)) dut_f (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    // One-hot invariant while a result is presented.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_e.out_valid === 1'b1) begin
            n_cmp++;
            if ($countones({bus_e.eq, bus_e.gt, bus_e.lt}) !== 1) begin
                n_bad++;
                $display("FAIL onehot_e: got %b want exactly one bit", {bus_e.eq, bus_e.gt, bus_e.lt});
            end
        end
        if (rst_n === 1'b1 && bus_f.out_valid === 1'b1) begin
            n_cmp++;
            if ($countones({bus_f.eq, bus_f.gt, bus_f.lt}) !== 1) begin
                n_bad++;
                $display("FAIL onehot_f: got %b want exactly one bit", {bus_f.eq, bus_f.gt, bus_f.lt});
            end
        end
    end

    // Reference model: result {eq,gt,lt} and nibbles examined.
    function automatic void model(input logic [15:0] av, input logic [15:0] bv, input bit ee,
                                  output logic [2:0] res, output logic [2:0] cnt);
        logic [15:0] x;
        int top;
        x   = av ^ bv;
        top = -1;
        res = (av == bv) ? 3'b100 : ((av > bv) ? 3'b010 : 3'b001);
        for (int i = 0; i < 16; i++) if (x[i]) top = i;
        if (!ee || top < 0) cnt = 3'(NIB);
        else                cnt = 3'(NIB - top / 4);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (!(bus_e.in_ready === 1'b1 && bus_f.in_ready === 1'b1) && c < 20) begin
            step();
            c++;
        end
        if (c >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: in_ready e=%b f=%b want 1", bus_e.in_ready, bus_f.in_ready);
        end
    endtask

    // Runs one operand pair through both DUTs with out_ready=1 and reports,
    // per DUT, latency, {eq,gt,lt}, count and in_ready one cycle after done.
    task automatic do_pair(input logic [15:0] av, input logic [15:0] bv,
                           output int lat_e, output int lat_f,
                           output logic [2:0] res_e, output logic [2:0] res_f,
                           output logic [2:0] cnt_e, output logic [2:0] cnt_f,
                           output logic rdy_e, output logic rdy_f);
        int c;
        bit se, sf, de, df;
        lat_e = -1; lat_f = -1; res_e = 'x; res_f = 'x; cnt_e = 'x; cnt_f = 'x;
        rdy_e = 1'bx; rdy_f = 1'bx;
        wait_idle();
        a_in = av; b_in = bv; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        se = 0; sf = 0; de = 0; df = 0; c = 0;
        while (!(de && df) && c < 40) begin
            step();
            c++;
            if (se && !de) begin rdy_e = bus_e.in_ready; de = 1; end
            if (sf && !df) begin rdy_f = bus_f.in_ready; df = 1; end
            if (!se && bus_e.out_valid === 1'b1) begin
                se = 1; lat_e = c; res_e = {bus_e.eq, bus_e.gt, bus_e.lt}; cnt_e = bus_e.count;
            end
            if (!sf && bus_f.out_valid === 1'b1) begin
                sf = 1; lat_f = c; res_f = {bus_f.eq, bus_f.gt, bus_f.lt}; cnt_f = bus_f.count;
            end
        end
        if (!(de && df)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_timeout: a=%h b=%h seen e=%0d f=%0d want both", av, bv, se, sf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a_in = 16'h1234; b_in = 16'h4321;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({bus_e.in_ready, bus_e.out_valid, bus_e.eq, bus_e.gt, bus_e.lt, bus_e.count} !== 8'b1000_0000 ||
                {bus_f.in_ready, bus_f.out_valid, bus_f.eq, bus_f.gt, bus_f.lt, bus_f.count} !== 8'b1000_0000) begin
                n_bad++;
                $display("FAIL reset_hold: e=%b f=%b want 10000000",
                         {bus_e.in_ready, bus_e.out_valid, bus_e.eq, bus_e.gt, bus_e.lt, bus_e.count},
                         {bus_f.in_ready, bus_f.out_valid, bus_f.eq, bus_f.gt, bus_f.lt, bus_f.count});
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        n_cmp++;
        if ({bus_e.in_ready, bus_e.out_valid, bus_e.eq, bus_e.gt, bus_e.lt, bus_e.count} !== 8'b1000_0000 ||
            {bus_f.in_ready, bus_f.out_valid, bus_f.eq, bus_f.gt, bus_f.lt, bus_f.count} !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL reset_release: e=%b f=%b want 10000000",
                     {bus_e.in_ready, bus_e.out_valid, bus_e.eq, bus_e.gt, bus_e.lt, bus_e.count},
                     {bus_f.in_ready, bus_f.out_valid, bus_f.eq, bus_f.gt, bus_f.lt, bus_f.count});
        end
    endtask

    // Directed vectors: {a, b, res_e, cnt_e, res_f, cnt_f}, latency == count.
    task automatic test_directed();
        logic [15:0] va [4] = '{16'h1234, 16'h9000, 16'h12A4, 16'hFFFF};
        logic [15:0] vb [4] = '{16'h1234, 16'h1FFF, 16'h12B0, 16'hFFFE};
        logic [2:0]  er [4] = '{3'b100, 3'b010, 3'b001, 3'b010};
        logic [2:0]  ec [4] = '{3'd4, 3'd1, 3'd3, 3'd4};
        int lat_e, lat_f;
        logic [2:0] res_e, res_f, cnt_e, cnt_f;
        logic rdy_e, rdy_f;
        for (int i = 0; i < 4; i++) begin
            do_pair(va[i], vb[i], lat_e, lat_f, res_e, res_f, cnt_e, cnt_f, rdy_e, rdy_f);
            n_cmp++;
            if (res_e !== er[i] || cnt_e !== ec[i] || lat_e != int'(ec[i]) || rdy_e !== 1'b1) begin
                n_bad++;
                $display("FAIL directed_e[%0d]: res=%b cnt=%0d lat=%0d rdy=%b want res=%b cnt=%0d lat=%0d rdy=1",
                         i, res_e, cnt_e, lat_e, rdy_e, er[i], ec[i], ec[i]);
            end
            n_cmp++;
            if (res_f !== er[i] || cnt_f !== 3'd4 || lat_f != 4 || rdy_f !== 1'b1) begin
                n_bad++;
                $display("FAIL directed_f[%0d]: res=%b cnt=%0d lat=%0d rdy=%b want res=%b cnt=4 lat=4 rdy=1",
                         i, res_f, cnt_f, lat_f, rdy_f, er[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int c;
        wait_idle();
        a_in = 16'h0001; b_in = 16'h0002; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        c = 0;
        while (bus_e.out_valid !== 1'b1 && c < 10) begin
            step();
            c++;
        end
        n_cmp++;
        if (c != 4) begin
            n_bad++;
            $display("FAIL bp_latency: got %0d cycles want 4", c);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            step();
            n_cmp++;
            if ({bus_e.out_valid, bus_e.eq, bus_e.gt, bus_e.lt, bus_e.count, bus_e.in_ready} !== 8'b1001_1000 ||
                {bus_f.out_valid, bus_f.eq, bus_f.gt, bus_f.lt, bus_f.count, bus_f.in_ready} !== 8'b1001_1000) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: e=%b f=%b want 10011000", i,
                         {bus_e.out_valid, bus_e.eq, bus_e.gt, bus_e.lt, bus_e.count, bus_e.in_ready},
                         {bus_f.out_valid, bus_f.eq, bus_f.gt, bus_f.lt, bus_f.count, bus_f.in_ready});
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if ({bus_e.out_valid, bus_e.in_ready, bus_e.lt, bus_e.count} !== 6'b01_1100 ||
            {bus_f.out_valid, bus_f.in_ready, bus_f.lt, bus_f.count} !== 6'b01_1100) begin
            n_bad++;
            $display("FAIL bp_release: e=%b f=%b want 011100",
                     {bus_e.out_valid, bus_e.in_ready, bus_e.lt, bus_e.count},
                     {bus_f.out_valid, bus_f.in_ready, bus_f.lt, bus_f.count});
        end
    endtask

    task automatic test_reset_mid();
        int lat_e, lat_f;
        logic [2:0] res_e, res_f, cnt_e, cnt_f;
        logic rdy_e, rdy_f;
        bit rose;
        wait_idle();
        a_in = 16'h1234; b_in = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        rose = (bus_e.out_valid !== 1'b0) || (bus_f.out_valid !== 1'b0);
        step();
        rose |= (bus_e.out_valid !== 1'b0) || (bus_f.out_valid !== 1'b0);
        rst_n = 1'b0;
        step();
        step();
        rose |= (bus_e.out_valid !== 1'b0) || (bus_f.out_valid !== 1'b0);
        rst_n = 1'b1;
        n_cmp++;
        if ({bus_e.in_ready, bus_e.eq, bus_e.gt, bus_e.lt, bus_e.count} !== 7'b100_0000 ||
            {bus_f.in_ready, bus_f.eq, bus_f.gt, bus_f.lt, bus_f.count} !== 7'b100_0000) begin
            n_bad++;
            $display("FAIL midreset_state: e=%b f=%b want 1000000",
                     {bus_e.in_ready, bus_e.eq, bus_e.gt, bus_e.lt, bus_e.count},
                     {bus_f.in_ready, bus_f.eq, bus_f.gt, bus_f.lt, bus_f.count});
        end
        for (int i = 0; i < 6; i++) begin
            step();
            rose |= (bus_e.out_valid !== 1'b0) || (bus_f.out_valid !== 1'b0);
        end
        n_cmp++;
        if (rose) begin
            n_bad++;
            $display("FAIL midreset_no_result: out_valid rose=1 want 0");
        end
        do_pair(16'h0000, 16'h0000, lat_e, lat_f, res_e, res_f, cnt_e, cnt_f, rdy_e, rdy_f);
        n_cmp++;
        if (res_e !== 3'b100 || cnt_e !== 3'd4 || res_f !== 3'b100 || cnt_f !== 3'd4) begin
            n_bad++;
            $display("FAIL midreset_next: e=%b/%0d f=%b/%0d want 100/4", res_e, cnt_e, res_f, cnt_f);
        end
    endtask

    task automatic test_random();
        int lat_e, lat_f;
        logic [2:0] res_e, res_f, cnt_e, cnt_f, xr_e, xc_e, xr_f, xc_f;
        logic rdy_e, rdy_f;
        logic [15:0] av, bv;
        for (int i = 0; i < 40; i++) begin
            av = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = 16'($urandom);
                2:       bv = av ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
                default: bv = av ^ 16'($urandom_range(1, 15));
            endcase
            model(av, bv, 1'b1, xr_e, xc_e);
            model(av, bv, 1'b0, xr_f, xc_f);
            do_pair(av, bv, lat_e, lat_f, res_e, res_f, cnt_e, cnt_f, rdy_e, rdy_f);
            n_cmp++;
            if (res_e !== xr_e || cnt_e !== xc_e || lat_e != int'(xc_e) || rdy_e !== 1'b1) begin
                n_bad++;
                $display("FAIL random_e a=%h b=%h: res=%b cnt=%0d lat=%0d rdy=%b want res=%b cnt=%0d lat=%0d rdy=1",
                         av, bv, res_e, cnt_e, lat_e, rdy_e, xr_e, xc_e, xc_e);
            end
            n_cmp++;
            if (res_f !== xr_f || cnt_f !== xc_f || lat_f != int'(xc_f) || rdy_f !== 1'b1) begin
                n_bad++;
                $display("FAIL random_f a=%h b=%h: res=%b cnt=%0d lat=%0d rdy=%b want res=%b cnt=%0d lat=%0d rdy=1",
                         av, bv, res_f, cnt_f, lat_f, rdy_f, xr_f, xc_f, xc_f);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
